// File: rtl/csla_mp_pkg.sv
// csla_mp_pkg: shared types and sizes for the multi-precision add sequencer.
// Optional subtract support is built when CSLA_MP_SUB_EN is defined.
package csla_mp_pkg;

  localparam int WORD_W      = 64;
  localparam int MAX_WORDS_D = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

endpackage

// File: rtl/csla_64.sv
// csla_64: 64-bit carry-select adder, four 16-bit blocks.
// Upper blocks precompute both carry-in cases and select on the chained carry.
module csla_64
  import csla_mp_pkg::*;
(
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  input  logic              cin,
  output logic [WORD_W-1:0] sum,
  output logic              cout
);

  localparam int BW = 16;
  localparam int NB = WORD_W / BW;

  logic [NB:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < NB; i++) begin : g_blk
    logic [BW:0] s0;
    logic [BW:0] s1;

    assign s0 = {1'b0, a[i*BW +: BW]}
              + {1'b0, b[i*BW +: BW]};
    assign s1 = s0 + {{BW{1'b0}}, 1'b1};

    assign sum[i*BW +: BW] = c[i] ? s1[BW-1:0]
                                  : s0[BW-1:0];
    assign c[i+1] = c[i] ? s1[BW] : s0[BW];
  end

  assign cout = c[NB];

endmodule

// File: rtl/csla_mp_ctrl.sv
// csla_mp_ctrl: streams word pairs LSW-first through one csla_64.
// Build with CSLA_MP_SUB_EN to add the sub port (a - b mode).
module csla_mp_ctrl
  import csla_mp_pkg::*;
#(
  parameter  int MAX_WORDS = MAX_WORDS_D,
  localparam int LEN_W     = $clog2(MAX_WORDS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              cin,
`ifdef CSLA_MP_SUB_EN
  input  logic              sub,
`endif
  output logic              busy,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [WORD_W-1:0] a,
  input  logic [WORD_W-1:0] b,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [WORD_W-1:0] sum,
  output logic              sum_last,
  output logic              done,
  output logic              cout
);

  state_t             state_q;
  state_t             state_d;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   cnt_q;
  logic               carry_q;
  logic [WORD_W-1:0]  sum_q;
  logic               sum_valid_q;
  logic               sum_last_q;
  logic               done_q;
  logic               cout_q;

  logic               len_ok;
  logic               start_ok;
  logic               acc;
  logic               last_beat;
  logic               fin;
  logic               sub_sel;
  logic [WORD_W-1:0]  b_eff;
  logic [WORD_W-1:0]  add_sum;
  logic               add_cout;

`ifdef CSLA_MP_SUB_EN
  logic               sub_q;

  // Subtract mode latched with the start command.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= 1'b0;
    end else if (start_ok) begin
      sub_q <= sub;
    end
  end

  assign sub_sel = sub;
  assign b_eff   = sub_q ? ~b : b;
`else
  assign sub_sel = 1'b0;
  assign b_eff   = b;
`endif

  assign len_ok    = (len != '0)
                  && (len <= LEN_W'(MAX_WORDS));
  assign start_ok  = start && len_ok
                  && (state_q == IDLE) && !done_q;
  assign acc       = a_valid && a_ready;
  assign last_beat = (cnt_q == len_q - LEN_W'(1));
  assign fin       = (state_q == FLUSH)
                  && sum_valid_q && sum_ready;

  csla_64 u_add (
    .a    (a),
    .b    (b_eff),
    .cin  (carry_q),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_ok) state_d = RUN;
      RUN:     if (acc && last_beat) state_d = FLUSH;
      FLUSH:   if (fin) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Handshake and status outputs.
  always_comb begin
    a_ready = 1'b0;
    busy    = done_q;
    unique case (1'b1)
      (state_q == RUN): begin
        a_ready = !sum_valid_q || sum_ready;
        busy    = 1'b1;
      end
      (state_q == FLUSH): busy = 1'b1;
      default: ;
    endcase
  end

  // Carry chain, beat counter and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_last_q  <= 1'b0;
      done_q      <= 1'b0;
      cout_q      <= 1'b0;
    end else begin
      done_q <= fin;
      if (start_ok) begin
        len_q   <= len;
        carry_q <= sub_sel ? 1'b1 : cin;
        cnt_q   <= '0;
        cout_q  <= 1'b0;
      end
      if (acc) begin
        sum_q       <= add_sum;
        carry_q     <= add_cout;
        sum_valid_q <= 1'b1;
        sum_last_q  <= last_beat;
        cnt_q       <= cnt_q + LEN_W'(1);
      end else if (sum_valid_q && sum_ready) begin
        sum_valid_q <= 1'b0;
        sum_last_q  <= 1'b0;
      end
      if (fin) begin
        cout_q <= carry_q;
      end
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum       = sum_q;
  assign sum_last  = sum_last_q;
  assign done      = done_q;
  assign cout      = cout_q;

endmodule
